// File: rtl/lvds_ser_pkg.sv
// Shared types and tag constants for the LVDS frame serializer.
package lvds_ser_pkg;
  typedef enum logic [1:0] {STREAM = 2'd0, RAMP_UP = 2'd1, RAMP_DN = 2'd2, CONST = 2'd3} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_e;

  localparam logic [7:0] UP_TAG = 8'hF0;
  localparam logic [3:0] DN_TAG = 4'hF;
endpackage

// File: rtl/lvds_lane_shifter.sv
// One serial lane: parallel load, LSB-first shift. Zero fill drains the lane to 0 after the last bit.
module lvds_lane_shifter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  bit_out
);
  logic [DATA_WIDTH-1:0] sh;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  sh <= '0;
    else if (load) sh <= word;
    else           sh <= sh >> 1;
  end

  assign bit_out = sh[0];
endmodule

// File: rtl/lvds_frame_serializer.sv
// Frame serializer: FSM, bit/word counters, pattern generator and stream handshake
// in front of LANES lane shifters.
module lvds_frame_serializer
  import lvds_ser_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 256,
  parameter int GAP_CYCLES = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [1:0]                  mode,
  input  logic [DATA_WIDTH-1:0]       const_word,
  input  logic [LANES*DATA_WIDTH-1:0] s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [LANES-1:0]            lane_data,
  output logic                        valid,
  output logic                        frame,
  output logic                        frame_done,
  output logic                        underflow,
  output logic                        busy,
  output logic [15:0]                 frame_cnt
);
  localparam int MW = $clog2(DATA_WIDTH);
  localparam int KW = $clog2(FRAME_LEN);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int PW = DATA_WIDTH - 8;

  localparam logic [MW-1:0] M_LAST = MW'(DATA_WIDTH - 1);
  localparam logic [MW-1:0] M_PEN  = MW'(DATA_WIDTH - 2);
  localparam logic [MW-1:0] M_HALF = MW'(DATA_WIDTH / 2 - 1);
  localparam logic [KW-1:0] K_LAST = KW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e                state;
  logic [MW-1:0]         m;
  logic [KW-1:0]         k;
  logic [GW-1:0]         gap_cnt;
  mode_e                 mode_q;
  logic [DATA_WIDTH-1:0] const_q;

  logic                  last_bit, word_end, gap_done, start, load;
  mode_e                 cur_mode;
  logic [DATA_WIDTH-1:0] cur_const;
  logic [KW-1:0]         k_nxt;
  logic [PW-1:0]         k_up, k_dn;

  assign last_bit = (state == SEND) && (m == M_LAST) && (k == K_LAST);
  assign word_end = (state == SEND) && (m == M_LAST) && (k != K_LAST);
  assign gap_done = (state == GAP) && (gap_cnt == G_LAST);
  // With no gap, the last bit of one frame doubles as the start point of the next.
  assign start    = enable && ((state == IDLE) || gap_done || ((GAP_CYCLES == 0) && last_bit));
  assign load     = start || word_end;

  // A frame start uses the live mode/const_word; mid-frame uses the latched copies.
  assign cur_mode  = start ? mode_e'(mode) : mode_q;
  assign cur_const = start ? const_word : const_q;
  assign k_nxt     = start ? '0 : k + 1'b1;
  assign k_up      = PW'(k_nxt);
  assign k_dn      = PW'(FRAME_LEN - 1) - k_up;

  assign s_ready = reset_n && load && (cur_mode == STREAM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      m          <= '0;
      k          <= '0;
      gap_cnt    <= '0;
      mode_q     <= STREAM;
      const_q    <= '0;
      valid      <= 1'b0;
      frame      <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      underflow  <= s_ready && !s_valid;
      if (start) begin
        mode_q  <= mode_e'(mode);
        const_q <= const_word;
      end
      if (load) begin
        state <= SEND;
        m     <= '0;
        k     <= k_nxt;
        valid <= 1'b1;
        frame <= 1'b1;
        busy  <= 1'b1;
      end else begin
        case (state)
          SEND: begin
            if (last_bit) begin
              state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
              busy    <= (GAP_CYCLES > 0);
              valid   <= 1'b0;
              frame   <= 1'b0;
              gap_cnt <= '0;
            end else begin
              m     <= m + 1'b1;
              frame <= (m < M_HALF);
              // Registered one cycle early so the pulse lines up with the last bit.
              if ((m == M_PEN) && (k == K_LAST)) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 1'b1;
              end
            end
          end
          GAP: begin
            if (gap_done) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam logic [7:0] LID = 8'(l);
    logic [DATA_WIDTH-1:0] word;

    always_comb begin
      word = '0;
      case (cur_mode)
        STREAM:  word = s_valid ? s_data[l*DATA_WIDTH +: DATA_WIDTH] : '0;
        RAMP_UP: word = {k_up, UP_TAG | LID};
        RAMP_DN: word = {k_dn, LID[3:0], DN_TAG};
        CONST:   word = cur_const;
        default: word = '0;
      endcase
    end

    lvds_lane_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shift (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (load),
      .word    (word),
      .bit_out (lane_data[l])
    );
  end
endmodule

// File: tb/tb_lvds_frame_serializer.sv
// Directed bench: default-parameter instance for ramps/stream/reset, plus an
// 8-lane 12-bit gapless instance for constant mode and back-to-back frames.
module tb_lvds_frame_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        en_a, s_valid, s_ready, valid_a, frame_a, done_a, udf_a, busy_a;
  logic [1:0]  mode_a;
  logic [15:0] const_a, cnt_a;
  logic [63:0] s_data;
  logic [3:0]  lane_a;

  logic        en_b, s_valid_b, s_ready_b, valid_b, frame_b, done_b, udf_b, busy_b;
  logic [1:0]  mode_b;
  logic [15:0] const_b16, cnt_b;
  logic [95:0] s_data_b;
  logic [7:0]  lane_b;

  lvds_frame_serializer u_dut_a (
    .clock(clk), .reset_n(reset_n), .enable(en_a), .mode(mode_a), .const_word(const_a),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .lane_data(lane_a),
    .valid(valid_a), .frame(frame_a), .frame_done(done_a), .underflow(udf_a),
    .busy(busy_a), .frame_cnt(cnt_a));

  lvds_frame_serializer #(.LANES(8), .DATA_WIDTH(12), .FRAME_LEN(4), .GAP_CYCLES(0)) u_dut_b (
    .clock(clk), .reset_n(reset_n), .enable(en_b), .mode(mode_b), .const_word(const_b16[11:0]),
    .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b), .lane_data(lane_b),
    .valid(valid_b), .frame(frame_b), .frame_done(done_b), .underflow(udf_b),
    .busy(busy_b), .frame_cnt(cnt_b));

  int checks, failures;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] src_word(input int h, input int l);
    return {4'(l), 4'hA, 8'(h)};
  endfunction

  // Deserialisers: rebuild words per lane from the serial outputs.
  logic [15:0] capa [0:255][0:3];
  logic [11:0] capb [0:3][0:7];
  int a_bit, a_word, a_vcnt, a_fbad, a_done;
  int b_bit, b_word, b_vcnt, b_fbad;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_bit = 0; a_word = 0; b_bit = 0; b_word = 0;
    end else begin
      if (valid_a) begin
        a_vcnt++;
        if (frame_a !== (a_bit < 8)) a_fbad++;
        for (int l = 0; l < 4; l++) capa[a_word][l][a_bit] = lane_a[l];
        if (a_bit == 15) begin a_bit = 0; a_word = (a_word + 1) % 256; end
        else a_bit++;
      end
      if (done_a) a_done++;
      if (valid_b) begin
        b_vcnt++;
        if (frame_b !== (b_bit < 6)) b_fbad++;
        for (int l = 0; l < 8; l++) capb[b_word][l][b_bit] = lane_b[l];
        if (b_bit == 11) begin b_bit = 0; b_word = (b_word + 1) % 4; end
        else b_bit++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #2 reset_n = 1'b0;
    @(negedge clk); @(negedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int v0, d0, f0, done_c, dn, gap, restarted, ld, hs, udf, ud_ld, err, falls, sr, dn2_c;
    logic prev;
    logic [15:0] exp_w;

    reset_n = 1'b1; en_a = 0; mode_a = 0; const_a = 0; s_data = '0; s_valid = 0;
    en_b = 0; mode_b = 0; const_b16 = 0; s_data_b = '0; s_valid_b = 0;
    #2 reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_a", {lane_a, valid_a, frame_a, done_a, udf_a, busy_a, s_ready, cnt_a}, 64'h0);
    check("rst_b", {lane_b, valid_b, frame_b, done_b, udf_b, busy_b, s_ready_b, cnt_b}, 64'h0);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Up-ramp, one frame
    mode_a = 2'd1; en_a = 1; v0 = a_vcnt; d0 = a_done; f0 = a_fbad; done_c = -1;
    for (int c = 1; c <= 4108; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("t1_first_bit", {valid_a, frame_a, busy_a, s_ready, lane_a}, {4'b1110, 4'b1010});
      end
      if (c == 8) check("t1_frame_hi_b7", frame_a, 1'b1);
      if (c == 9) check("t1_frame_lo_b8", frame_a, 1'b0);
      if (c == 17) check("t1_frame_w1", frame_a, 1'b1);
      if (done_a && done_c < 0) done_c = c;
      if (c == 4000) en_a = 0;
    end
    check("t1_valid_cycles", a_vcnt - v0, 4096);
    check("t1_done_cycle", done_c, 4096);
    check("t1_done_count", a_done - d0, 1);
    check("t1_frame_cnt", cnt_a, 1);
    check("t1_l2_w5", capa[5][2], 16'h05F2);
    check("t1_l3_w255", capa[255][3], 16'hFFF3);
    check("t1_frame_marker", a_fbad - f0, 0);
    check("t1_idle", {busy_a, valid_a, lane_a}, 6'h0);

    // Down-ramp, two frames with gap; mode wiggled mid-frame must not matter
    do_reset();
    mode_a = 2'd2; en_a = 1; dn = 0; gap = 0; restarted = 0; d0 = a_done;
    for (int c = 1; c <= 8215; c++) begin
      @(negedge clk);
      if (done_a) begin
        dn++;
        if (dn == 1) check("t2_mode_latched", capa[200][1], 16'h371F);
      end
      if (dn == 1 && !valid_a) gap++;
      if (dn == 1 && gap > 0 && valid_a && restarted == 0) begin
        restarted = 1; en_a = 0;
        check("t2_f2_bit0", lane_a, 4'hF);
      end
      if (c == 100) mode_a = 2'd3;
      if (c == 2000) mode_a = 2'd2;
    end
    check("t2_gap_len", gap, 8);
    check("t2_frame_cnt", cnt_a, 2);
    check("t2_done_count", a_done - d0, 2);
    check("t2_l1_w0", capa[0][1], 16'hFF1F);
    check("t2_l0_w3", capa[3][0], 16'hFC0F);

    // Stream with s_valid dropped for word 10
    do_reset();
    mode_a = 2'd0; en_a = 1; ld = 0; hs = 0; udf = 0; ud_ld = -1;
    for (int c = 0; c < 4120; c++) begin
      if (udf_a) begin udf++; ud_ld = ld; end
      if (c == 2000) en_a = 0;
      s_valid = (ld != 10);
      for (int l = 0; l < 4; l++) s_data[l*16 +: 16] = src_word(hs, l);
      #1;
      if (s_ready) begin
        ld++;
        if (s_valid) hs++;
      end
      @(negedge clk);
    end
    s_valid = 0;
    check("t3_handshakes", hs, 255);
    check("t3_load_points", ld, 256);
    check("t3_underflow_cnt", udf, 1);
    check("t3_underflow_at", ud_ld, 11);
    check("t3_word10_zero", {capa[10][3], capa[10][2], capa[10][1], capa[10][0]}, 64'h0);
    err = 0;
    for (int w = 0; w < 256; w++) begin
      for (int l = 0; l < 4; l++) begin
        exp_w = (w < 10) ? src_word(w, l) : (w == 10) ? 16'h0 : src_word(w - 1, l);
        if (capa[w][l] !== exp_w) err++;
      end
    end
    check("t3_stream_words", err, 0);
    check("t3_frame_cnt", cnt_a, 1);

    // Asynchronous reset at word 100, then restart from word 0
    mode_a = 2'd1; en_a = 1;
    for (int c = 1; c <= 1605; c++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t4_async_clear", {lane_a, valid_a, frame_a, done_a, udf_a, busy_a, s_ready, cnt_a}, 64'h0);
    @(negedge clk); #2 reset_n = 1'b1;
    v0 = a_vcnt;
    @(negedge clk);
    check("t4_restart_bit0", {valid_a, frame_a, lane_a}, {2'b11, 4'b1010});
    for (int c = 2; c <= 4110; c++) begin
      @(negedge clk);
      if (c == 50) en_a = 0;
    end
    check("t4_valid_cycles", a_vcnt - v0, 4096);
    check("t4_l3_w0", capa[0][3], 16'h00F3);
    check("t4_l0_w100", capa[100][0], 16'h64F0);
    check("t4_frame_cnt", cnt_a, 1);

    // Constant mode, 8 lanes x 12 bits, gapless frames, enable dropped in frame 3
    mode_b = 2'd3; const_b16 = 16'hA5C3; en_b = 1;
    dn = 0; falls = 0; prev = 1'b0; sr = 0; dn2_c = 100000; v0 = b_vcnt; f0 = b_fbad;
    for (int c = 1; c <= 160; c++) begin
      @(negedge clk);
      if (c == 1) check("t5_bit0", lane_b, 8'hFF);
      if (c == 3) check("t5_bit2", lane_b, 8'h00);
      if (c == 6) check("t5_frame_hi_b5", frame_b, 1'b1);
      if (c == 7) check("t5_frame_lo_b6", frame_b, 1'b0);
      if (prev && !valid_b) falls++;
      prev = valid_b;
      if (s_ready_b) sr++;
      if (done_b) begin
        dn++;
        if (dn == 2) dn2_c = c;
      end
      if (c == dn2_c + 10) en_b = 0;
    end
    check("t5_valid_cycles", b_vcnt - v0, 144);
    check("t5_valid_falls", falls, 1);
    check("t5_frame_cnt", cnt_b, 3);
    check("t5_idle", {busy_b, valid_b}, 2'b00);
    check("t5_no_ready", sr, 0);
    check("t5_frame_marker", b_fbad - f0, 0);
    err = 0;
    for (int w = 0; w < 4; w++)
      for (int l = 0; l < 8; l++)
        if (capb[w][l] !== 12'h5C3) err++;
    check("t5_const_words", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
